// File: rtl/r2r_wave_pkg.sv
// Shared types and constants for the R2R ladder waveform generator.
package r2r_wave_pkg;

  typedef enum logic [1:0] {
    EXT = 2'd0,
    SAW = 2'd1,
    TRI = 2'd2,
    SQR = 2'd3
  } wave_mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } gen_state_t;

  localparam logic [7:0] DIV_RST    = 8'd9;
  localparam logic [7:0] STEP_RST   = 8'd1;
  localparam logic [7:0] MIDSCALE   = 8'h80;
  localparam int         STEP_SHIFT = 4;

  // Ladder code for one sample, taken from the top 9 phase bits.
  function automatic logic [7:0] wave_code(input wave_mode_t m, input logic [8:0] p,
                                           input logic [7:0] ext);
    logic [7:0] code;
    case (m)
      EXT:     code = ext;
      SAW:     code = p[8:1];
      TRI:     code = p[8] ? ~p[7:0] : p[7:0];
      SQR:     code = p[8] ? 8'hFF : 8'h00;
      default: code = MIDSCALE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/r2r_wave_gen_sync_rise.sv
// Two-flop pin synchroniser with a rising-edge detector; the detector only
// arms once the synchronised level has been seen low after reset.
module sync_rise #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] level,
  output logic [W-1:0] rise
);

  logic [W-1:0] meta_r;
  logic [W-1:0] sync_r;
  logic [W-1:0] prev_r;
  logic [W-1:0] armed_r;
  logic [1:0]   valid_r;

  // synchroniser chain, edge history and arming
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r  <= '0;
      sync_r  <= '0;
      prev_r  <= '0;
      armed_r <= '0;
      valid_r <= 2'b00;
    end else begin
      meta_r  <= d;
      sync_r  <= meta_r;
      prev_r  <= sync_r;
      valid_r <= {valid_r[0], 1'b1};
      // a pin held high across reset release never looks like a new edge
      armed_r <= armed_r | ({W{valid_r[1]}} & ~sync_r);
    end
  end

  assign level = sync_r;
  assign rise  = sync_r & ~prev_r & armed_r;

endmodule

// File: rtl/r2r_wave_gen.sv
// Paced 8-bit sample source for an R2R ladder: external byte, sawtooth,
// triangle or square codes at a programmable tick rate.
module r2r_wave_gen
  import r2r_wave_pkg::*;
#(
  parameter int PHASE_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       load_div,
  input  logic       load_step,
  input  logic [1:0] mode,
  input  logic       run,
  output logic [7:0] r2r_out,
  output logic       sample_tick
);

  logic               div_rise_s;
  logic               step_rise_s;
  logic               div_level_unused;
  logic               step_level_unused;
  logic [2:0]         ctl_level_s;
  logic [2:0]         ctl_rise_unused;
  logic               run_s;
  wave_mode_t         mode_s;
  gen_state_t         state_r;
  gen_state_t         state_next_s;
  logic [7:0]         div_r;
  logic [7:0]         step_r;
  logic [7:0]         cnt_r;
  logic [PHASE_W-1:0] phase_r;
  logic [PHASE_W-1:0] phase_inc_s;
  logic               active_s;
  logic               tick_s;
  logic [7:0]         r2r_out_r;
  logic               sample_tick_r;

  sync_rise #(.W(1)) u_div_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (load_div),
    .level (div_level_unused),
    .rise  (div_rise_s)
  );

  sync_rise #(.W(1)) u_step_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (load_step),
    .level (step_level_unused),
    .rise  (step_rise_s)
  );

  sync_rise #(.W(3)) u_ctl_sync (
    .clk   (clk),
    .rst   (rst),
    .d     ({mode, run}),
    .level (ctl_level_s),
    .rise  (ctl_rise_unused)
  );

  assign run_s       = ctl_level_s[0];
  assign mode_s      = wave_mode_t'(ctl_level_s[2:1]);
  assign phase_inc_s = PHASE_W'(step_r) << STEP_SHIFT;
  // the exit cycle (RUN with run already low) counts as inactive
  assign active_s    = (state_r == RUN) && run_s;
  assign tick_s      = active_s && (cnt_r == div_r) && !div_rise_s;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = run_s ? RUN : IDLE;
      RUN:     state_next_s = run_s ? RUN : IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // divider and phase-step registers; simultaneous strobes load the same byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r  <= DIV_RST;
      step_r <= STEP_RST;
    end else begin
      if (div_rise_s) begin
        div_r <= data;
      end
      if (step_rise_s) begin
        step_r <= data;
      end
    end
  end

  // pace counter and phase accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= 8'd0;
      phase_r <= '0;
    end else if (!active_s) begin
      cnt_r   <= 8'd0;
      phase_r <= '0;
    end else begin
      if (div_rise_s || (cnt_r == div_r)) begin
        cnt_r <= 8'd0;
      end else begin
        cnt_r <= cnt_r + 8'd1;
      end
      if (tick_s) begin
        phase_r <= phase_r + phase_inc_s;
      end
    end
  end

  // output sample register, updated only on ticks so mode changes cannot glitch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r2r_out_r     <= 8'h00;
      sample_tick_r <= 1'b0;
    end else begin
      sample_tick_r <= tick_s;
      if (!active_s) begin
        r2r_out_r <= MIDSCALE;
      end else if (tick_s) begin
        r2r_out_r <= wave_code(mode_s, phase_r[PHASE_W-1 -: 9], data);
      end
    end
  end

  assign r2r_out     = r2r_out_r;
  assign sample_tick = sample_tick_r;

endmodule

// File: tb/tb_r2r_wave_gen.sv
// Self-checking bench for r2r_wave_gen: table of waveform runs scored through
// an expected-sample queue, plus hand sequences for strobe, exit and reset.
module tb_r2r_wave_gen;
  import r2r_wave_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       load_div;
  logic       load_step;
  logic [1:0] mode;
  logic       run;
  logic [7:0] r2r_out;
  logic       sample_tick;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    wave_mode_t m;
    bit         do_load;
    logic [7:0] dv;
    logic [7:0] st;
    int         n;
    int         first_lat;
    int         period;
  } vec_t;

  vec_t vecs[6];

  r2r_wave_gen #(.PHASE_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .data        (data),
    .load_div    (load_div),
    .load_step   (load_step),
    .mode        (mode),
    .run         (run),
    .r2r_out     (r2r_out),
    .sample_tick (sample_tick)
  );

  always #50 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] exp_code(input wave_mode_t m, input logic [15:0] ph);
    logic [8:0] p;
    p = ph[15:7];
    case (m)
      SAW:     return p[8:1];
      TRI:     return p[8] ? ~p[7:0] : p[7:0];
      SQR:     return p[8] ? 8'hFF : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  task automatic load_reg(input bit is_step, input logic [7:0] val);
    @(negedge clk);
    data = val;
    if (is_step) load_step = 1'b1;
    else load_div = 1'b1;
    repeat (4) @(negedge clk);
    load_div  = 1'b0;
    load_step = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // drop run and check midscale three clocks later, then silence
  task automatic check_exit(input string tag);
    int ticks;
    run = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, " exit_code"}, r2r_out, 8'h80);
    check({tag, " exit_tick"}, sample_tick, 1'b0);
    ticks = 0;
    repeat (12) begin
      @(negedge clk);
      if (sample_tick) ticks++;
    end
    check({tag, " idle_ticks"}, ticks, 0);
  endtask

  task automatic run_samples(input wave_mode_t m, input logic [7:0] st, input int n,
                             input int first_lat, input int period, input string tag);
    logic [15:0] ph;
    logic [7:0]  e;
    int cyc, got, last, budget;
    ph = 16'd0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(exp_code(m, ph));
      ph = ph + ({8'd0, st} << 4);
    end
    budget = n * period + first_lat + 40;
    cyc = 0; got = 0; last = 0;
    @(negedge clk);
    mode = m;
    run  = 1'b1;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (sample_tick) begin
        e = exp_q.pop_front();
        check({tag, " code"}, r2r_out, e);
        if (got == 0) check({tag, " first_lat"}, cyc, first_lat);
        else check({tag, " period"}, cyc - last, period);
        last = cyc;
        got++;
      end
    end
    if (got < n) begin
      check({tag, " timeout_samples"}, got, n);
      exp_q.delete();
    end
    check_exit(tag);
  endtask

  initial begin
    int ticks, bad, cyc;
    rst = 1'b1; data = 8'h00; load_div = 1'b0; load_step = 1'b0;
    mode = 2'd0; run = 1'b0;

    vecs[0] = '{SAW, 1'b0, 8'd9, 8'd1,    40,   13, 10};
    vecs[1] = '{SQR, 1'b1, 8'd0, 8'h80,   40,   4,  1};
    vecs[2] = '{TRI, 1'b1, 8'd0, 8'h10,   300,  4,  1};
    vecs[3] = '{SAW, 1'b1, 8'd0, 8'd1,    4100, 4,  1};
    vecs[4] = '{SQR, 1'b1, 8'd2, 8'h40,   30,   6,  3};
    vecs[5] = '{SAW, 1'b1, 8'd5, 8'd0,    10,   9,  6};

    repeat (3) @(negedge clk);
    check("reset r2r_out", r2r_out, 8'h00);
    check("reset sample_tick", sample_tick, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("idle midscale first clock", r2r_out, 8'h80);
    ticks = 0; bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (sample_tick) ticks++;
      if (r2r_out !== 8'h80) bad++;
    end
    check("idle ticks", ticks, 0);
    check("idle code errors", bad, 0);

    foreach (vecs[k]) begin
      if (vecs[k].do_load) begin
        load_reg(1'b0, vecs[k].dv);
        load_reg(1'b1, vecs[k].st);
      end
      run_samples(vecs[k].m, vecs[k].st, vecs[k].n, vecs[k].first_lat,
                  vecs[k].period, $sformatf("vec%0d", k));
    end

    // ext mode, div=3: output follows data sampled at each tick
    load_reg(1'b0, 8'd3);
    @(negedge clk);
    mode = EXT; run = 1'b1; data = 8'($urandom_range(255));
    ticks = 0; cyc = 0; bad = 0;
    while (ticks < 12 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (sample_tick) begin
        check("ext code", r2r_out, data);
        if (ticks > 0) check("ext period", cyc - bad, 4);
        bad = cyc;
        ticks++;
      end
      data = 8'($urandom_range(255));
    end
    check("ext sample count", ticks, 12);
    check_exit("ext");

    // div strobe mid-run: counter restarts three clocks after the pin rise
    load_reg(1'b0, 8'd9);
    @(negedge clk);
    mode = SAW; run = 1'b1;
    cyc = 0;
    while (!sample_tick && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("strobe wait tick", sample_tick, 1'b1);
    data = 8'd0; load_div = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("strobe latency clk%0d", k), sample_tick, (k == 4));
    end
    load_div = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("strobe div0 every clock", sample_tick, 1'b1);
    end
    check_exit("strobe");

    // asynchronous reset in the middle of an ext-mode run
    @(negedge clk);
    mode = EXT; data = 8'h5A; run = 1'b1;
    cyc = 0;
    while (!sample_tick && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("prereset code", r2r_out, 8'h5A);
    repeat (2) @(negedge clk);
    rst = 1'b1; run = 1'b0;
    #1;
    check("async rst r2r_out", r2r_out, 8'h00);
    check("async rst tick", sample_tick, 1'b0);
    repeat (3) @(negedge clk);
    check("held rst r2r_out", r2r_out, 8'h00);
    // a div strobe held high through release must not load
    data = 8'h00; load_div = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post rst midscale", r2r_out, 8'h80);
    repeat (6) @(negedge clk);
    load_div = 1'b0;
    repeat (5) @(negedge clk);
    run_samples(SAW, 8'd1, 40, 13, 10, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
